// File: rtl/btn_debounce_level.sv
// Push-button conditioner: 2-flop synchronizer, polarity fix and counter-based debounce FSM.
// Optional auto-repeat (one-cycle low gaps while held) under BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_level #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic busy_o
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic            RelVal = ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gen_bad_params
    $error("btn_debounce_level: cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s1_q, s2_q, pressed_s;
  logic            level_q, busy_q;
  logic [CntW-1:0] cnt_inc;
  logic            cnt_done;
  logic            hold_hit;

  assign pressed_s = ACTIVE_LOW ? ~s2_q : s2_q;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
  // This sample is the DEBOUNCE_CYCLES-th agreeing one.
  assign cnt_done  = (cnt_q >= CntMax - CntOne);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned HoldMaxVal = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW      = $clog2(HoldMaxVal + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_CYCLES - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             rep_q, rep_d;

  assign hold_hit = rep_q ? (hold_q >= RepLast) : (hold_q >= HoldLast);

  // Hold count runs across GAP so gaps land on a fixed REPEAT_CYCLES grid.
  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    if (state_q == StPressed && state_d == StGap) begin
      hold_d = '0;
      rep_d  = 1'b1;
    end else if (state_d == StPressed && (state_q == StPressed || state_q == StGap)) begin
      hold_d = hold_q + HoldW'(1);
    end else if (state_d != StGap) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StReleased: begin
        if (pressed_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StPressed;
          end else begin
            state_d = StPressWait;
            cnt_d   = CntOne;
          end
        end
      end
      StPressWait: begin
        if (!pressed_s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        if (!pressed_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StReleased;
          end else begin
            state_d = StReleaseWait;
            cnt_d   = CntOne;
          end
        end else if (hold_hit) begin
          state_d = StGap;
        end
      end
      StReleaseWait: begin
        if (pressed_s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGap: begin
        // Released samples here are ignored; release is qualified from PRESSED.
        state_d = StPressed;
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= RelVal;
      s2_q    <= RelVal;
      state_q <= StReleased;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == StPressed) || (state_d == StReleaseWait);
      busy_q  <= (state_d == StPressWait) || (state_d == StReleaseWait);
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_btn_debounce_level.sv
// Directed self-checking bench for btn_debounce_level (DEBOUNCE_CYCLES=4, active-low key).
// Expects auto-repeat gaps only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module tb_btn_debounce_level;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic level, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rises   = 0;
  logic lvl_prev = 1'b0;

  btn_debounce_level #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn),
    .level_o(level),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  // Downstream rising-edge detector: one count per enable pulse.
  always @(negedge clk) begin
    if (level && !lvl_prev) rises = rises + 1;
    lvl_prev = level;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting edges after which level differs from want.
  task automatic hold_check(input int n, input logic want, output int viol);
    viol = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (level !== want) viol++;
    end
  endtask

  int viol, base, gaps, pat_err;

  initial begin
    step(3);
    rst = 1'b0;

    // Idle after reset with key released.
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (level !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("idle_after_reset", viol, 0);

    // Clean press: busy after edge 3, level after edge 6.
    base = rises;
    btn = 1'b0;
    step(2);
    check("press_busy_e2", busy, 0);
    step(1);
    check("press_busy_e3", busy, 1);
    check("press_lvl_e3", level, 0);
    step(2);
    check("press_lvl_e5", level, 0);
    step(1);
    check("press_lvl_e6", level, 1);
    check("press_busy_e6", busy, 0);

    // Clean release.
    btn = 1'b1;
    step(5);
    check("rel_lvl_e5", level, 1);
    check("rel_busy_e5", busy, 1);
    step(1);
    check("rel_lvl_e6", level, 0);
    check("rel_busy_e6", busy, 0);
    check("clean_press_pulses", rises - base, 1);

    // Press bounce: low 3, high 1, then low steady.
    base = rises;
    btn = 1'b0;
    step(3);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    hold_check(5, 1'b0, viol);
    check("bounce_press_hold0", viol, 0);
    step(1);
    check("bounce_press_rise", level, 1);

    // Release bounce: high 1, low 2, then high steady.
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    hold_check(5, 1'b1, viol);
    check("bounce_rel_hold1", viol, 0);
    step(1);
    check("bounce_rel_fall", level, 0);
    check("bounce_pulses", rises - base, 1);

    // Short glitches of 1..3 cycles never qualify.
    base = rises;
    viol = 0;
    for (int w = 1; w <= 3; w++) begin
      int v;
      btn = 1'b0;
      step(w);
      btn = 1'b1;
      hold_check(10, 1'b0, v);
      viol += v;
    end
    check("glitch_no_level", viol, 0);
    check("glitch_no_pulse", rises - base, 0);

    // Long hold: auto-repeat gaps at PRESSED cycles 10, 15, 20, 25.
    base = rises;
    btn = 1'b0;
    step(6);
    check("hold_rise", level, 1);
    gaps = 0;
    pat_err = 0;
    for (int i = 1; i <= 29; i++) begin
      logic want;
      step(1);
      want = !(AutoRep && (i == 10 || i == 15 || i == 20 || i == 25));
      if (level === 1'b0) gaps++;
      if (level !== want) pat_err++;
    end
    check("gap_count", gaps, AutoRep ? 4 : 0);
    check("gap_pattern", pat_err, 0);
    check("hold_pulses", rises - base, AutoRep ? 5 : 1);
    btn = 1'b1;
    step(8);
    check("hold_release", level, 0);

    // Reset while PRESSED, key released with it: forced 0, no later edge.
    btn = 1'b0;
    step(6);
    check("pre_rst_lvl", level, 1);
    rst = 1'b1;
    btn = 1'b1;
    step(1);
    check("rst_lvl", level, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    base = rises;
    hold_check(20, 1'b0, viol);
    check("post_rst_quiet", viol, 0);
    check("post_rst_no_pulse", rises - base, 0);

    // Key held across reset release: one rise, 6 edges after deassertion.
    rst = 1'b1;
    btn = 1'b0;
    step(3);
    check("rst_held_lvl", level, 0);
    base = rises;
    rst = 1'b0;
    hold_check(5, 1'b0, viol);
    check("held_rst_wait", viol, 0);
    step(1);
    check("held_rst_rise", level, 1);
    step(3);
    check("held_rst_pulses", rises - base, 1);
    btn = 1'b1;
    step(10);
    check("held_rst_release", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
